// File: rtl/enc_dec_apb_master.sv
// Command/response front end driving a single APB requester port.
// One transaction in flight; misaligned commands are answered with an error without touching APB.
module enc_dec_apb_master #(
    parameter int unsigned AMBA_ADDR_WIDTH = 32,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic [AMBA_WORD-1:0]       pwdata,
    input  logic [AMBA_WORD-1:0]       prdata,
    input  logic                       pready,
    input  logic                       pslverr,
    output logic                       busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [CW-1:0]              r_cnt;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic                       r_pwrite;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic [AMBA_WORD-1:0]       r_rdata;
    logic                       r_err;
    logic                       w_accept;
    logic                       w_misaligned;
    logic                       w_timeout;

    assign w_accept     = cmd_valid && (r_state == IDLE);
    assign w_misaligned = (cmd_addr[1:0] != 2'b00);
    // Abort on the wait cycle that would bring the counter to TIMEOUT_CYCLES; pready in that cycle still wins.
    assign w_timeout    = (r_state == ACCESS) && !pready && (r_cnt == LAST_WAIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_misaligned ? RESP : SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (pready || w_timeout) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE) && rstn;
        psel      = (r_state == SETUP) || (r_state == ACCESS);
        penable   = (r_state == ACCESS);
        rsp_valid = (r_state == RESP);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= '0;
            if (w_misaligned) begin
                r_err <= 1'b1;
            end else begin
                r_err    <= 1'b0;
                r_cnt    <= '0;
                r_paddr  <= cmd_addr;
                r_pwrite <= cmd_write;
                r_pwdata <= cmd_write ? cmd_wdata : '0;
            end
        end else if (r_state == ACCESS) begin
            if (pready) begin
                r_err   <= pslverr;
                r_rdata <= (!r_pwrite && !pslverr) ? prdata : '0;
            end else if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_enc_dec_apb_master.sv
// Vector table plus randomized transactions against a transaction-level model of the APB requester.
module tb_enc_dec_apb_master;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        busy;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [31:0] last_addr = '0;

    enc_dec_apb_master #(
        .AMBA_ADDR_WIDTH(32),
        .AMBA_WORD      (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prd;
        int unsigned waits;
        logic        slv;
        int unsigned hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int unsigned exp_acc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Transaction-level expectation: error/data/ACCESS-cycle count from the command and completer behaviour.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.addr[1:0] != 2'b00) begin
            r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_acc = 0;
        end else if (v.waits >= TO) begin
            r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_acc = TO;
        end else begin
            r.exp_err = v.slv; r.exp_rdata = (v.wr || v.slv) ? 32'h0 : v.prd; r.exp_acc = v.waits + 1;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] prd, input int unsigned waits, input logic slv,
                                input int unsigned hold, input logic e_err, input logic [31:0] e_rd,
                                input int unsigned e_acc);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.prd = prd; v.waits = waits; v.slv = slv;
        v.hold = hold; v.exp_err = e_err; v.exp_rdata = e_rd; v.exp_acc = e_acc;
        return v;
    endfunction

    // Called and returns just after a falling edge.
    task automatic run_txn(input vec_t v);
        int unsigned acc = 0;
        int unsigned setups = 0;
        int unsigned lat = 0;
        int unsigned w = 0;
        logic seen = 1'b0;
        logic aligned;
        logic [31:0] hold_rd;
        logic hold_er;
        aligned = (v.addr[1:0] == 2'b00);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        chk("cmd_ready_before_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid) begin seen = 1'b1; lat = c; break; end
            if (psel) begin
                chk("paddr", paddr, v.addr);
                chk("pwrite", pwrite, v.wr);
                chk("pwdata", pwdata, v.wr ? v.wdata : 32'h0);
            end
            if (psel && !penable) setups++;
            if (psel && penable) begin
                acc++;
                pready  = (acc > v.waits);
                prdata  = pready ? v.prd : $urandom;
                pslverr = pready ? v.slv : 1'($urandom);
            end else begin
                pready = $urandom; prdata = $urandom; pslverr = $urandom;
            end
            @(negedge clk);
        end
        pready = 1'b0;
        chk("rsp_seen", seen, 1);
        if (aligned) last_addr = v.addr;
        chk("setup_cycles", setups, aligned ? 1 : 0);
        chk("access_cycles", acc, v.exp_acc);
        chk("latency", lat, aligned ? v.exp_acc + 1 : 0);
        chk("psel_in_resp", {psel, penable}, 0);
        chk("paddr_hold", paddr, last_addr);
        chk("cmd_ready_in_resp", cmd_ready, 0);
        chk("busy_in_resp", busy, 1);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        hold_rd = rsp_rdata; hold_er = rsp_err;
        rsp_ready = 1'b0;
        repeat (v.hold) begin
            @(negedge clk);
            chk("rsp_valid_held", rsp_valid, 1);
            chk("rsp_stable", {hold_er, hold_rd}, {rsp_err, rsp_rdata});
            chk("cmd_ready_held_low", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", rsp_valid, 0);
        chk("cmd_ready_after_hs", cmd_ready, 1);
        chk("busy_after_hs", busy, 0);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        #1;
        chk("reset_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, busy, cmd_ready}, 0);
        chk("reset_data", {paddr, pwdata, rsp_rdata}, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        tbl.push_back(mk(1'b1, 32'h4,  32'hDEAD_BEEF, 32'h1234_5678, 0,   1'b0, 0, 1'b0, 32'h0,         1));
        tbl.push_back(mk(1'b0, 32'h8,  32'h5555_AAAA, 32'h0000_0007, 3,   1'b0, 0, 1'b0, 32'h7,         4));
        tbl.push_back(mk(1'b0, 32'hC,  32'h0,         32'h9999_9999, 100, 1'b0, 0, 1'b1, 32'h0,         16));
        tbl.push_back(mk(1'b1, 32'h2,  32'h1111_2222, 32'h0,         0,   1'b0, 0, 1'b1, 32'h0,         0));
        tbl.push_back(mk(1'b0, 32'h10, 32'h0,         32'hFFFF_FFFF, 0,   1'b1, 5, 1'b1, 32'h0,         1));
        tbl.push_back(mk(1'b0, 32'h14, 32'h0,         32'h0000_A5A5, 15,  1'b0, 1, 1'b0, 32'h0000_A5A5, 16));
        tbl.push_back(mk(1'b1, 32'h18, 32'hCAFE_F00D, 32'h0,         2,   1'b1, 0, 1'b1, 32'h0,         3));
        tbl.push_back(mk(1'b0, 32'h1D, 32'h0,         32'h0,         0,   1'b0, 2, 1'b1, 32'h0,         0));
        tbl.push_back(mk(1'b0, 32'h20, 32'h0,         32'h8765_4321, 16,  1'b0, 0, 1'b1, 32'h0,         16));
        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset pulse in the middle of an ACCESS wait phase.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("reset_test_in_access", {psel, penable}, 2'b11);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_ctrl", {psel, penable, rsp_valid, busy, cmd_ready}, 0);
        chk("async_reset_paddr", paddr, 0);
        @(negedge clk);
        rstn = 1'b1;
        last_addr = '0;
        @(negedge clk);
        chk("post_reset_no_rsp", {rsp_valid, busy, cmd_ready}, 3'b001);
        run_txn(mk(1'b0, 32'h44, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 0, 1'b0, 32'h0BAD_F00D, 2));

        for (int i = 0; i < 25; i++) begin
            rv.wr = 1'($urandom);
            rv.addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rv.addr[1:0] = 2'($urandom_range(1, 3));
            rv.wdata = $urandom;
            rv.prd = $urandom;
            rv.waits = $urandom_range(0, 20);
            rv.slv = ($urandom_range(0, 4) == 0);
            rv.hold = $urandom_range(0, 3);
            run_txn(model(rv));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
